// File: rtl/pe_cluster_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_cluster_pkg
// Brief    : Shared constants and row-state encoding for the PE-cluster
//            iact broadcast controller.
// Revision : 1.0
// ============================================================================
package pe_cluster_pkg;

    localparam int ROWS   = 3;
    localparam int COLS   = 3;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 13;
    localparam int LEN_W  = 5;

    typedef enum logic [1:0] {
        ROW_IDLE = 2'd0,
        ROW_ADDR = 2'd1,
        ROW_DATA = 2'd2,
        ROW_DONE = 2'd3
    } row_state_e;

endpackage
`default_nettype wire

// File: rtl/iact_row_bcast_fsm.sv
`default_nettype none
// ============================================================================
// Module   : iact_row_bcast_fsm
// Brief    : One PE row: forks each router word (address then data phase)
//            to all COLS PEs, each PE consuming every word exactly once.
// Revision : 1.0
// ============================================================================
module iact_row_bcast_fsm
    import pe_cluster_pkg::*;
#(
    parameter int COLS  = pe_cluster_pkg::COLS,
    parameter int LEN_W = pe_cluster_pkg::LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             all_done,
    input  logic [LEN_W-1:0] addr_len,
    input  logic [LEN_W-1:0] data_len,
    input  logic             rtr_addr_valid,
    output logic             rtr_addr_ready,
    input  logic             rtr_data_valid,
    output logic             rtr_data_ready,
    output logic [COLS-1:0]  pe_addr_valid,
    input  logic [COLS-1:0]  pe_addr_ready,
    output logic [COLS-1:0]  pe_data_valid,
    input  logic [COLS-1:0]  pe_data_ready,
    output logic             row_idle,
    output logic             row_done
);

    row_state_e       r_state, w_state_nxt, w_phase_nxt;
    logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
    logic [COLS-1:0]  r_taken, w_taken_nxt;

    logic [LEN_W-1:0] w_len;
    logic             w_xfer;
    logic             w_rtr_valid;
    logic             w_rtr_ready;
    logic             w_rtr_hs;
    logic             w_last;
    logic [COLS-1:0]  w_pe_ready;
    logic [COLS-1:0]  w_pe_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ROW_IDLE;
            r_cnt   <= '0;
            r_taken <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_taken <= w_taken_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_taken_nxt    = r_taken;
        pe_addr_valid  = '0;
        pe_data_valid  = '0;
        rtr_addr_ready = 1'b0;
        rtr_data_ready = 1'b0;
        row_idle       = (r_state == ROW_IDLE);
        row_done       = (r_state == ROW_DONE);

        // Shared fork datapath, steered by the active phase
        w_phase_nxt = (r_state == ROW_ADDR) ? ROW_DATA : ROW_DONE;
        w_len       = (r_state == ROW_ADDR) ? addr_len       : data_len;
        w_rtr_valid = (r_state == ROW_ADDR) ? rtr_addr_valid : rtr_data_valid;
        w_pe_ready  = (r_state == ROW_ADDR) ? pe_addr_ready  : pe_data_ready;
        w_xfer      = ((r_state == ROW_ADDR) || (r_state == ROW_DATA)) && (w_len != '0);
        w_pe_valid  = (w_xfer && w_rtr_valid) ? ~r_taken : '0;
        w_rtr_ready = w_xfer && (&(r_taken | w_pe_ready));
        w_rtr_hs    = w_rtr_ready && w_rtr_valid;
        w_last      = (r_cnt == (w_len - LEN_W'(1)));

        case (r_state)
            ROW_IDLE: begin
                if (go) begin
                    w_state_nxt = ROW_ADDR;
                    w_cnt_nxt   = '0;
                    w_taken_nxt = '0;
                end
            end
            ROW_ADDR, ROW_DATA: begin
                if (r_state == ROW_ADDR) begin
                    pe_addr_valid  = w_pe_valid;
                    rtr_addr_ready = w_rtr_ready;
                end else begin
                    pe_data_valid  = w_pe_valid;
                    rtr_data_ready = w_rtr_ready;
                end

                // Zero-length phase is skipped after a single idle cycle
                if (w_len == '0) begin
                    w_state_nxt = w_phase_nxt;
                    w_cnt_nxt   = '0;
                    w_taken_nxt = '0;
                end else if (w_rtr_hs) begin
                    w_taken_nxt = '0;
                    if (w_last) begin
                        w_state_nxt = w_phase_nxt;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + LEN_W'(1);
                    end
                end else begin
                    w_taken_nxt = r_taken | (w_pe_valid & w_pe_ready);
                end
            end
            ROW_DONE: begin
                if (all_done) begin
                    w_state_nxt = ROW_IDLE;
                end
            end
            default: begin
                w_state_nxt = ROW_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pe_cluster_iact_bcast_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pe_cluster_iact_bcast_ctrl
// Brief    : Broadcasts per-row router iact address/data words to every PE
//            of the row; latches lengths and joins row completion.
// Revision : 1.0
// ============================================================================
module pe_cluster_iact_bcast_ctrl
    import pe_cluster_pkg::*;
#(
    parameter int ROWS   = pe_cluster_pkg::ROWS,
    parameter int COLS   = pe_cluster_pkg::COLS,
    parameter int ADDR_W = pe_cluster_pkg::ADDR_W,
    parameter int DATA_W = pe_cluster_pkg::DATA_W,
    parameter int LEN_W  = pe_cluster_pkg::LEN_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [LEN_W-1:0]            cfg_addr_len,
    input  logic [LEN_W-1:0]            cfg_data_len,
    input  logic [ROWS-1:0]             rtr_addr_valid,
    output logic [ROWS-1:0]             rtr_addr_ready,
    input  logic [ROWS*ADDR_W-1:0]      rtr_addr_bits,
    input  logic [ROWS-1:0]             rtr_data_valid,
    output logic [ROWS-1:0]             rtr_data_ready,
    input  logic [ROWS*DATA_W-1:0]      rtr_data_bits,
    output logic [ROWS*COLS-1:0]        pe_addr_valid,
    input  logic [ROWS*COLS-1:0]        pe_addr_ready,
    output logic [ROWS*COLS*ADDR_W-1:0] pe_addr_bits,
    output logic [ROWS*COLS-1:0]        pe_data_valid,
    input  logic [ROWS*COLS-1:0]        pe_data_ready,
    output logic [ROWS*COLS*DATA_W-1:0] pe_data_bits,
    output logic                        busy,
    output logic [ROWS-1:0]             row_done,
    output logic                        load_done
);

    logic [LEN_W-1:0] r_addr_len;
    logic [LEN_W-1:0] r_data_len;
    logic [ROWS-1:0]  w_row_idle;
    logic             w_all_idle;
    logic             w_all_done;
    logic             w_go;

    assign w_all_idle = &w_row_idle;
    assign w_all_done = &row_done;
    assign w_go       = start && w_all_idle;
    assign busy       = !w_all_idle;
    assign load_done  = w_all_done;

    // Lengths are captured only when a load is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_len <= '0;
            r_data_len <= '0;
        end else if (w_go) begin
            r_addr_len <= cfg_addr_len;
            r_data_len <= cfg_data_len;
        end
    end

    generate
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            iact_row_bcast_fsm #(
                .COLS  (COLS),
                .LEN_W (LEN_W)
            ) u_row (
                .clk            (clk),
                .rst_n          (rst_n),
                .go             (w_go),
                .all_done       (w_all_done),
                .addr_len       (r_addr_len),
                .data_len       (r_data_len),
                .rtr_addr_valid (rtr_addr_valid[r]),
                .rtr_addr_ready (rtr_addr_ready[r]),
                .rtr_data_valid (rtr_data_valid[r]),
                .rtr_data_ready (rtr_data_ready[r]),
                .pe_addr_valid  (pe_addr_valid[r*COLS +: COLS]),
                .pe_addr_ready  (pe_addr_ready[r*COLS +: COLS]),
                .pe_data_valid  (pe_data_valid[r*COLS +: COLS]),
                .pe_data_ready  (pe_data_ready[r*COLS +: COLS]),
                .row_idle       (w_row_idle[r]),
                .row_done       (row_done[r])
            );

            for (genvar c = 0; c < COLS; c++) begin : g_col
                assign pe_addr_bits[(r*COLS+c)*ADDR_W +: ADDR_W] = rtr_addr_bits[r*ADDR_W +: ADDR_W];
                assign pe_data_bits[(r*COLS+c)*DATA_W +: DATA_W] = rtr_data_bits[r*DATA_W +: DATA_W];
            end
        end
    endgenerate

endmodule
`default_nettype wire
